// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared pipeline constants (FSM states, zero register, forwarding selects)
package hazard_stall_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: saturating up-counter; ports clk_i, rst_i (async active-low clear), inc_i, cnt_o
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_o <= '0;
    else if (inc_i && cnt_o != '1) cnt_o <= cnt_o + W'(1);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/branch/dmem-wait sequencing; in: clk_i rst_i IDEX_* IFID_* Branch_taken_i dmem_*; out: PC/IFID enables, flush, bubble, hold, error, perf counters
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RtAddr_i,
  input  logic [4:0]       IFID_RsAddr_i,
  input  logic [4:0]       IFID_RtAddr_i,
  input  logic             Branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             pipe_hold_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic mem_stall, load_use, frozen;
  always_comb begin
    mem_stall = state == RUN ? dmem_req_i & ~dmem_ack_i : state == MEM_WAIT ? ~dmem_ack_i : 1'b0;
    load_use = rst_i & IDEX_MemRead_i & (IDEX_RtAddr_i != REG_ZERO)
             & (IDEX_RtAddr_i == IFID_RsAddr_i | IDEX_RtAddr_i == IFID_RtAddr_i);
    // inputs are masked while reset is held so the outputs show RUN defaults
    frozen = rst_i & (state == ERROR | mem_stall);
    pipe_hold_o = frozen;
    IDEX_bubble_o = ~frozen & load_use;
    PC_write_o = ~(frozen | load_use);
    IFID_write_o = ~(frozen | load_use);
    IFID_flush_o = rst_i & ~frozen & ~load_use & Branch_taken_i;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= RUN;
      wait_cnt <= '0;
      error_o <= 1'b0;
    end else begin
      case (state)
        RUN:
          if (dmem_req_i && !dmem_ack_i) begin
            state <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end
        MEM_WAIT:
          if (dmem_ack_i) begin
            state <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(TIMEOUT)) begin
            state <= ERROR;
            error_o <= 1'b1;
          end else wait_cnt <= wait_cnt + WW'(1);
        default: begin
          state <= ERROR;
          error_o <= 1'b1;
        end
      endcase
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(~PC_write_o & (state != ERROR)),
    .cnt_o(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(IFID_flush_o),
    .cnt_o(flush_cnt_o)
  );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl (TIMEOUT=4, CNT_W=4)
module tb_hazard_stall_ctrl;
  logic clk = 1'b0, rst_i = 1'b0;
  logic mr = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
  logic [4:0] rt = '0, rs = '0, rtid = '0;
  logic pcw, ifw, fl, bub, hold, err;
  logic [3:0] scnt, fcnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .IDEX_MemRead_i(mr), .IDEX_RtAddr_i(rt), .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rtid),
    .Branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
    .PC_write_o(pcw), .IFID_write_o(ifw), .IFID_flush_o(fl), .IDEX_bubble_o(bub),
    .pipe_hold_o(hold), .error_o(err), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic m, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic t, input logic q, input logic k);
    mr = m; rt = a; rs = b; rtid = c; br = t; req = q; ack = k;
    #1;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  // packs {PC_write, IFID_write, flush, bubble, hold, error}
  function automatic logic [5:0] outs();
    return {pcw, ifw, fl, bub, hold, err};
  endfunction
  initial begin
    drive(1, 5'd8, 5'd8, 5'd0, 1, 1, 0);
    check("reset_masked", 32'(outs()), 32'b110000);
    check("reset_cnts", {24'd0, scnt, fcnt}, 32'd0);
    repeat (2) cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_i = 1'b1;
    #1;
    check("idle", 32'(outs()), 32'b110000);
    cyc;
    drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
    check("lu_outs", 32'(outs()), 32'b000100);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("lu_cnt", 32'(scnt), 32'd1);
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("lu_r0", 32'(outs()), 32'b110000);
    cyc;
    check("lu_r0_cnt", 32'(scnt), 32'd1);
    drive(1, 5'd5, 5'd1, 5'd5, 1, 0, 0);
    check("lu_br", 32'(outs()), 32'b000100);
    cyc;
    drive(0, 5'd5, 5'd1, 5'd5, 1, 0, 0);
    check("br_flush", 32'(outs()), 32'b111000);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("br_cnts", {24'd0, scnt, fcnt}, {24'd0, 4'd2, 4'd1});
    drive(0, 0, 0, 0, 0, 1, 0);
    check("mw_hold0", 32'(outs()), 32'b000010);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("mw_hold1", 32'(outs()), 32'b000010);
    cyc;
    check("mw_hold2", 32'(outs()), 32'b000010);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 1);
    check("mw_ack", 32'(outs()), 32'b110000);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("mw_run", 32'(outs()), 32'b110000);
    check("mw_cnt", 32'(scnt), 32'd5);
    drive(0, 0, 0, 0, 0, 1, 1);
    check("zero_wait", 32'(outs()), 32'b110000);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("zero_wait_run", 32'(outs()), 32'b110000);
    drive(1, 5'd8, 5'd8, 5'd0, 0, 1, 0);
    check("lu_memstall", 32'(outs()), 32'b000010);
    cyc;
    drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 1);
    check("lu_after_ack", 32'(outs()), 32'b000100);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("lu_ms_cnt", 32'(scnt), 32'd7);
    drive(1, 5'd9, 5'd0, 5'd9, 0, 0, 0);
    repeat (10) cyc;
    check("sat_cnt", 32'(scnt), 32'd15);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_i = 1'b0;
    #1;
    check("rst_clear", {24'd0, scnt, fcnt}, 32'd0);
    @(negedge clk) rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("to_wait_err", 32'(err), 32'd0);
      cyc;
    end
    check("to_last_wait", 32'(outs()), 32'b000010);
    cyc;
    check("to_err", 32'(outs()), 32'b000011);
    check("to_cnt", 32'(scnt), 32'd5);
    drive(0, 0, 0, 0, 1, 0, 1);
    check("err_late_ack", 32'(outs()), 32'b000011);
    cyc;
    cyc;
    check("err_frozen", {24'd0, scnt, fcnt}, {24'd0, 4'd5, 4'd0});
    check("err_sticky", 32'(err), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst_i = 1'b0;
    #1;
    check("err_rst", 32'(outs()), 32'b110000);
    check("err_rst_cnt", {24'd0, scnt, fcnt}, 32'd0);
    @(negedge clk) rst_i = 1'b1;
    cyc;
    check("post_rst_run", 32'(outs()), 32'b110000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
